// File: rtl/lif_sched_pkg.sv
// Shared types and constants for the LIF neuron scheduler.
// Optional feature macro: LIF_SCHED_REFRACTORY_EN (see lif_sched.sv).
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CALC = 2'd2
  } state_t;

  localparam int LIF_WIDTH = 8;
  localparam int IDX_W     = 3;
  localparam int MEM_D     = 1 << IDX_W;

  localparam logic CFG_SEL_IEXT   = 1'b0;
  localparam logic CFG_SEL_THRESH = 1'b1;

  function automatic logic [3:0] popcount8(input logic [7:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF step: leak, external drive, inhibition, clamp and threshold.
module lif_update_core #(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] i_ext,
  input  logic [WIDTH-1:0] thresh,
  input  logic [WIDTH+1:0] inh,
  output logic [WIDTH-1:0] v_nxt,
  output logic             spk
);

  localparam int SW = WIDTH + 2;

  logic [WIDTH-1:0] leak;
  logic [SW-1:0]    s;
  logic [WIDTH-1:0] s_clamp;

  assign leak = v >> LEAK_SHIFT;

  // Two guard bits hold the full signed range; the top bit flags a negative sum.
  always_comb begin
    s = {2'b00, v} - {2'b00, leak} + {2'b00, i_ext} - inh;
    if (s[SW-1]) begin
      s_clamp = '0;
    end else if (s[SW-2]) begin
      s_clamp = '1;
    end else begin
      s_clamp = s[WIDTH-1:0];
    end
    spk   = (s_clamp >= thresh);
    v_nxt = spk ? '0 : s_clamp;
  end

endmodule

// File: rtl/lif_sched.sv
// Time-multiplexed LIF scheduler: one shared update core swept over all virtual neurons per tick.
// Define LIF_SCHED_REFRACTORY_EN to add per-neuron refractory counters.
module lif_sched
  import lif_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = LIF_WIDTH,
  parameter int LEAK_SHIFT  = 3,
  parameter int W_INH       = 4,
  parameter int REFRAC      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]       rd_voltage,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   done,
  output logic                   busy,
  output logic                   overrun
);

  localparam int N  = NUM_NEURONS;
  localparam int SW = WIDTH + 2;

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] v_mem    [MEM_D];
  logic [WIDTH-1:0] iext_mem [MEM_D];
  logic [WIDTH-1:0] thr_mem  [MEM_D];
  logic [WIDTH-1:0] op_v, op_iext, op_thr;
  logic [N-1:0]     spk_nxt, spk_merge, bit_n, peer;
  logic [3:0]       peer_cnt;
  logic [SW-1:0]    inh;
  logic [WIDTH-1:0] core_v_nxt, v_wr;
  logic             core_spk, spk_wr;
  logic             last_idx, cfg_hit;

  assign busy      = (state != IDLE);
  assign cfg_ready = ~busy;
  assign last_idx  = (idx == IDX_W'(N - 1));
  assign cfg_hit   = cfg_we && !busy && ({1'b0, cfg_addr} < (IDX_W + 1)'(N));

  // Inhibition counts only peers that spiked in the previous completed step.
  assign bit_n    = N'(1) << idx;
  assign peer     = spike_vec & ~bit_n;
  assign peer_cnt = popcount8(8'(peer));
  assign inh      = SW'(W_INH) * SW'(peer_cnt);

  lif_update_core #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_core (
    .v      (op_v),
    .i_ext  (op_iext),
    .thresh (op_thr),
    .inh    (inh),
    .v_nxt  (core_v_nxt),
    .spk    (core_spk)
  );

`ifdef LIF_SCHED_REFRACTORY_EN
  localparam int RC_W = 4;
  localparam logic [RC_W-1:0] REFRAC_L = RC_W'(REFRAC);

  logic [RC_W-1:0] refrac_cnt [MEM_D];
  logic            refrac_active;

  assign refrac_active = (refrac_cnt[idx] != '0);

  always_comb begin
    v_wr   = core_v_nxt;
    spk_wr = core_spk;
    if (refrac_active) begin
      v_wr   = '0;
      spk_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_D; i++) begin
        refrac_cnt[i] <= '0;
      end
    end else if (state == CALC) begin
      if (refrac_active) begin
        refrac_cnt[idx] <= refrac_cnt[idx] - 1'b1;
      end else if (core_spk) begin
        refrac_cnt[idx] <= REFRAC_L;
      end
    end
  end
`else
  always_comb begin
    v_wr   = core_v_nxt;
    spk_wr = core_spk;
  end
`endif

  assign spk_merge = (spk_nxt & ~bit_n) | (spk_wr ? bit_n : '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = READ;
      READ:    state_nxt = CALC;
      CALC:    state_nxt = last_idx ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Config writes are only taken in IDLE, so they never race the sweep's operand reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      op_v       <= '0;
      op_iext    <= '0;
      op_thr     <= '0;
      spk_nxt    <= '0;
      spike_vec  <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      rd_voltage <= '0;
      for (int i = 0; i < MEM_D; i++) begin
        v_mem[i]    <= '0;
        iext_mem[i] <= '0;
        thr_mem[i]  <= '0;
      end
    end else begin
      state      <= state_nxt;
      done       <= 1'b0;
      rd_voltage <= v_mem[rd_addr];
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      if (cfg_hit) begin
        if (cfg_sel == CFG_SEL_THRESH) begin
          thr_mem[cfg_addr] <= cfg_data;
        end else begin
          iext_mem[cfg_addr] <= cfg_data;
        end
      end
      case (state)
        IDLE: begin
          if (tick) begin
            idx     <= '0;
            spk_nxt <= '0;
          end
        end
        READ: begin
          op_v    <= v_mem[idx];
          op_iext <= iext_mem[idx];
          op_thr  <= thr_mem[idx];
        end
        CALC: begin
          v_mem[idx] <= v_wr;
          spk_nxt    <= spk_merge;
          if (last_idx) begin
            spike_vec <= spk_merge;
            done      <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
